if_prefetch_buf: RTL and testbench

//  Instruction prefetch queue between the instruction memory and the IF/ID register of the 5-stage pipe.

---
 rtl/if_prefetch_buf.sv | 142 ++++++++++++++
 tb/tb_if_prefetch_buf.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_buf.sv
// if_prefetch_buf: instruction prefetch queue between instruction memory and IF/ID.
// Fetches sequential words ahead of the pipeline over a level req/ack port into a
// small FIFO. It presents the head entry (instruction, PC, PC+4) combinationally.
// A redirect flushes the queue and restarts fetch at the new address. An in-flight
// request is carried to completion and its data is dropped.
// Optional build macro IF_PERF_CNT_EN adds perf_bubble_cnt and perf_redirect_cnt.
module if_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic        imem_req,
  output logic [9:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  logic [31:0]      ins_mem [DEPTH];
  logic [31:0]      pc_mem  [DEPTH];
  logic [31:0]      fetch_pc;
  logic [9:0]       drop_addr;
  logic             push;
  logic             pop;

  // Head entry and memory port are pure decodes of the registered state. While a
  // dropped transaction completes, the old word address stays on the bus.
  assign if_valid     = (count != '0);
  assign if_ins       = ins_mem[rd_ptr];
  assign if_pc        = pc_mem[rd_ptr];
  assign if_pc_plus_4 = pc_mem[rd_ptr] + 32'd4;
  assign imem_req     = (state != IDLE);
  assign imem_addr    = (state == DROP) ? drop_addr : fetch_pc[11:2];

  // Next-state logic: redirect wins. A request is only issued while room remains, so
  // count+push never exceeds DEPTH.
  always_comb begin
    pop         = if_valid & if_ready & ~redirect;
    push        = (state == BUSY) & imem_ack & ~redirect;
    count_after = count + CNT_W'(push) - CNT_W'(pop);
    state_next  = state;
    case (state)
      IDLE: begin
        if (!redirect && (count < DEPTH_C)) state_next = BUSY;
      end
      BUSY: begin
        if (redirect)      state_next = imem_ack ? IDLE : DROP;
        else if (imem_ack) state_next = (count_after < DEPTH_C) ? BUSY : IDLE;
      end
      DROP: begin
        if (imem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FIFO storage, pointers and occupancy; redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ins_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]  <= fetch_pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_after;
    end
  end

  // Fetch address: reload on redirect, advance only when a word is accepted.
  always_ff @(posedge clk) begin
    if (rst)           fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
    else if (push)     fetch_pc <= fetch_pc + 32'd4;
  end

  // Capture the in-flight word address when a pending request becomes a drop.
  always_ff @(posedge clk) begin
    if (rst)                                         drop_addr <= '0;
    else if ((state == BUSY) && redirect && !imem_ack) drop_addr <= fetch_pc[11:2];
  end

`ifdef IF_PERF_CNT_EN
  // Performance counters: starved-consumer cycles and redirect cycles, free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt   <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (!if_valid && if_ready) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (redirect)              perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_buf.sv
// tb_if_prefetch_buf: bench for if_prefetch_buf. It runs a vector table, directed
// corner sequences and randomized traffic, all scored against a queue-based model.
module tb_if_prefetch_buf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_redirect_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  if_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_ready(if_ready), .if_valid(if_valid), .if_ins(if_ins), .if_pc(if_pc),
    .if_pc_plus_4(if_pc_plus_4), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata)
`ifdef IF_PERF_CNT_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_fpc = 32'h0000_3000;
  logic        m_out = 1'b0;
  logic        m_drop = 1'b0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_bub = '0;
  logic [31:0] m_rc = '0;

  function automatic logic [31:0] memw(input logic [9:0] a);
    return {12'hA5C, a, ~a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Apply the rules of one clock edge to the abstract queue/transaction model.
  task automatic model_update();
    logic done;
    logic was_idle;
    int   sz0;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_fpc  = 32'h0000_3000;
      m_out  = 1'b0;
      m_drop = 1'b0;
      m_addr = '0;
      m_bub  = '0;
      m_rc   = '0;
    end else begin
      if (m_q.size() == 0 && if_ready) m_bub = m_bub + 32'd1;
      if (redirect) m_rc = m_rc + 32'd1;
      done = m_out && imem_ack;
      if (redirect) begin
        m_q.delete();
        if (m_out && !done) m_drop = 1'b1;
        else begin
          m_out  = 1'b0;
          m_drop = 1'b0;
        end
        m_fpc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        was_idle = !m_out;
        sz0 = m_q.size();
        if (m_q.size() != 0 && if_ready) void'(m_q.pop_front());
        if (done) begin
          if (!m_drop) begin
            e.pc  = m_fpc;
            e.ins = imem_rdata;
            m_q.push_back(e);
            m_fpc = m_fpc + 32'd4;
          end
          if (!m_drop && m_q.size() < DEPTH) m_addr = m_fpc[11:2];
          else m_out = 1'b0;
          m_drop = 1'b0;
        end else if (was_idle && sz0 < DEPTH) begin
          m_out  = 1'b1;
          m_addr = m_fpc[11:2];
        end
      end
    end
  endtask

  task automatic model_cmp();
    chk("m_valid", 32'(if_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("m_pc", if_pc, m_q[0].pc);
      chk("m_ins", if_ins, m_q[0].ins);
      chk("m_pc4", if_pc_plus_4, m_q[0].pc + 32'd4);
    end
    chk("m_req", 32'(imem_req), 32'(m_out));
    if (m_out) chk("m_addr", 32'(imem_addr), 32'(m_addr));
`ifdef IF_PERF_CNT_EN
    chk("m_bubble_cnt", perf_bubble_cnt, m_bub);
    chk("m_redirect_cnt", perf_redirect_cnt, m_rc);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    model_cmp();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        ready;
    logic        ack;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic [9:0]  exp_addr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic rdy, input logic a, input logic ev,
                              input logic [31:0] epc, input logic erq, input logic [9:0] ead);
    vec_t v;
    v.rst = r; v.ready = rdy; v.ack = a; v.exp_valid = ev;
    v.exp_pc = epc; v.exp_req = erq; v.exp_addr = ead;
    return v;
  endfunction

  initial begin
    logic [9:0] prev_addr;

    // ---- reset state ----
    tick();
    tick();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_ins", if_ins, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc_plus_4, 32'd4);

    // ---- table: fill with consumer stalled, then drain and resume at 0-wait ----
    vt.push_back(mk(1, 0, 0, 0, 32'h0, 0, 10'd0));
    vt.push_back(mk(0, 0, 1, 0, 32'h0, 1, 10'd0));
    vt.push_back(mk(0, 0, 1, 1, 32'h3000, 1, 10'd1));
    vt.push_back(mk(0, 0, 1, 1, 32'h3000, 1, 10'd2));
    vt.push_back(mk(0, 0, 1, 1, 32'h3000, 1, 10'd3));
    for (int i = 0; i < 6; i++) vt.push_back(mk(0, 0, 1, 1, 32'h3000, 0, 10'd0));
    vt.push_back(mk(0, 1, 1, 1, 32'h3004, 0, 10'd0));
    vt.push_back(mk(0, 1, 1, 1, 32'h3008, 1, 10'd4));
    vt.push_back(mk(0, 1, 1, 1, 32'h300C, 1, 10'd5));
    vt.push_back(mk(0, 1, 1, 1, 32'h3010, 1, 10'd6));
    vt.push_back(mk(0, 1, 1, 1, 32'h3014, 1, 10'd7));
    vt.push_back(mk(0, 1, 1, 1, 32'h3018, 1, 10'd8));
    prev_addr = '0;
    foreach (vt[i]) begin
      rst = vt[i].rst; redirect = 1'b0; if_ready = vt[i].ready;
      imem_ack = vt[i].ack; imem_rdata = memw(prev_addr);
      tick();
      chk("tbl_valid", 32'(if_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk("tbl_pc", if_pc, vt[i].exp_pc);
        chk("tbl_ins", if_ins, memw(vt[i].exp_pc[11:2]));
        chk("tbl_pc4", if_pc_plus_4, vt[i].exp_pc + 32'd4);
      end
      chk("tbl_req", 32'(imem_req), 32'(vt[i].exp_req));
      if (vt[i].exp_req) chk("tbl_addr", 32'(imem_addr), 32'(vt[i].exp_addr));
      prev_addr = vt[i].exp_addr;
    end

    // ---- 3 wait states, redirect to exception vector mid-transaction ----
    rst = 1'b1; if_ready = 1'b0; imem_ack = 1'b0; tick();
    rst = 1'b0; tick();
    chk("wv_req", 32'(imem_req), 32'd1);
    chk("wv_addr0", 32'(imem_addr), 32'h000);
    tick();
    redirect = 1'b1; redirect_pc = 32'h8000_0180; tick(); redirect = 1'b0;
    chk("wv_req_held", 32'(imem_req), 32'd1);
    chk("wv_addr_held", 32'(imem_addr), 32'h000);
    chk("wv_valid_flush", 32'(if_valid), 32'd0);
    tick();
    chk("wv_addr_held2", 32'(imem_addr), 32'h000);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; tick(); imem_ack = 1'b0;
    chk("wv_drop_req", 32'(imem_req), 32'd0);
    chk("wv_drop_valid", 32'(if_valid), 32'd0);
    tick();
    chk("wv_new_req", 32'(imem_req), 32'd1);
    chk("wv_new_addr", 32'(imem_addr), 32'h060);
    tick(); tick(); tick();
    chk("wv_wait_addr", 32'(imem_addr), 32'h060);
    chk("wv_wait_valid", 32'(if_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = memw(10'h060); tick(); imem_ack = 1'b0;
    chk("wv_valid", 32'(if_valid), 32'd1);
    chk("wv_pc", if_pc, 32'h8000_0180);
    chk("wv_ins", if_ins, memw(10'h060));
    chk("wv_pc4", if_pc_plus_4, 32'h8000_0184);

    // ---- redirect + pop + ack in one cycle with two entries queued ----
    rst = 1'b1; tick();
    rst = 1'b0; if_ready = 1'b0; imem_ack = 1'b1; imem_rdata = memw(m_addr); tick();
    imem_rdata = memw(m_addr); tick();
    imem_rdata = memw(m_addr); tick();
    chk("rpa_pre_pc", if_pc, 32'h3000);
    redirect = 1'b1; redirect_pc = 32'h0000_0102; if_ready = 1'b1;
    imem_rdata = memw(m_addr); tick();
    redirect = 1'b0; imem_ack = 1'b0;
    chk("rpa_valid", 32'(if_valid), 32'd0);
    chk("rpa_req", 32'(imem_req), 32'd0);
    tick();
    chk("rpa_valid2", 32'(if_valid), 32'd0);
    chk("rpa_addr", 32'(imem_addr), 32'h040);
    imem_ack = 1'b1; imem_rdata = memw(10'h040); tick(); imem_ack = 1'b0;
    chk("rpa_pc", if_pc, 32'h0000_0100);

    // ---- reset asserted with the queue full ----
    rst = 1'b1; tick();
    rst = 1'b0; if_ready = 1'b0; imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imem_rdata = memw(m_addr);
      tick();
    end
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(if_valid), 32'd1);
    rst = 1'b1; tick();
    chk("frst_valid", 32'(if_valid), 32'd0);
    chk("frst_req", 32'(imem_req), 32'd0);
    rst = 1'b0; imem_rdata = memw(10'd0); tick();
    chk("frst_addr", 32'(imem_addr), 32'h000);
    imem_rdata = memw(10'd0); tick();
    chk("frst_pc", if_pc, 32'h3000);
    imem_ack = 1'b0;

`ifdef IF_PERF_CNT_EN
    // ---- performance counters ----
    rst = 1'b1; if_ready = 1'b0; imem_ack = 1'b0; tick();
    chk("perf_rst_bub", perf_bubble_cnt, 32'd0);
    chk("perf_rst_rc", perf_redirect_cnt, 32'd0);
    rst = 1'b0; tick(); tick();
    for (int i = 0; i < 3; i++) begin
      redirect = 1'b1; redirect_pc = 32'h8000_0180; tick();
      redirect = 1'b0; tick();
    end
    if_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    if_ready = 1'b0; tick();
    chk("perf_rc", perf_redirect_cnt, 32'd3);
    chk("perf_bub", perf_bubble_cnt, 32'd5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("perf_rst2_bub", perf_bubble_cnt, 32'd0);
    chk("perf_rst2_rc", perf_redirect_cnt, 32'd0);
`endif

    // ---- randomized traffic against the model ----
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int mode;
      mode = (c / 250) % 3;
      rst = ($urandom_range(0, 299) == 0);
      redirect = ($urandom_range(0, 24) == 0);
      redirect_pc = $urandom;
      if_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 9) < 3)
                                                   : ($urandom_range(0, 9) < 7);
      imem_ack = m_out ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      imem_rdata = (m_out && imem_ack) ? memw(m_addr) : $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
